timer_reg_core: RTL and testbench
=================================

# timer_reg_core

Write-side register file and counting engine of the APB timer. It accepts decoded write transfers from the APB slave front end, holds every timer register, and runs the 64-bit counter, clock divider and compare-match interrupt. Its register outputs feed the read-data multiplexer, so writes and reads share one address map: 0x00 TCR, 0x04 TDR0, 0x08 TDR1, 0x0C TCMP0, 0x10 TCMP1, 0x14 TIER, 0x18 TISR.

## Interface
- DIV_MAX, 8, largest legal TCR.div_val; writes above it are rejected
- pclk  in  1  system clock; all state updates on rising edge
- presetn  in  1  asynchronous active-low reset
- wr_en  in  1  single-cycle write strobe from APB front end (access phase)
- addr  in  32  byte address of the write; only exact word offsets above decode
- wdata  in  32  write data
- wstrb  in  4  byte-lane enables; lane n updates bits [8n+7:8n]
- tcr, tdr_0, tdr_1, tcmp0, tcmp1, tier, tisr  out  32 each  current register values
- wr_err  out  1  combinational; high while wr_en is high and the write is rejected
- tim_int  out  1  registered interrupt, equal to tisr[0] & tier[0]

## Operation
- Reset values:
  - tcr = 0x0000_0100: div_val = 1, div_en = 0, timer_en = 0.
  - tdr_0 = tdr_1 = 0, tier = 0, tisr = 0.
  - tcmp0 = tcmp1 = 0xFFFF_FFFF.
  - wr_err = 0, tim_int = 0.
  - Internal divider count = 0.
- TCR fields:
  - bit0 timer_en, bit1 div_en, bits[11:8] div_val. All other bits are reserved and read 0.
  - Writes to reserved bits are ignored.
- Rejected TCR write: the whole write is dropped and wr_err = 1 in that cycle when, after lane merge, either condition holds:
  - div_val > DIV_MAX; or
  - timer_en is currently 1 and the write changes div_en or div_val.
- Other addresses:
  - A write to an undecoded address is ignored; wr_err = 0.
  - TIER: only bit0 (int_en) is writable. TISR: only bit0 (int_st) exists.
  - TCMP0 and TCMP1 are fully writable under byte strobes.
- Counter {tdr_1, tdr_0}, 64-bit:
  - Increments by 1 on each tick while timer_en = 1 and wraps from all-ones to 0.
  - div_en = 0: a tick occurs every cycle.
  - div_en = 1: a tick occurs every 2^div_val cycles. The divider counts 0..2^div_val-1 and ticks on the terminal value; div_val = 0 ticks every cycle.
  - The divider is held at 0 while timer_en = 0 or div_en = 0.
  - Clearing timer_en freezes the counter at its current value; it is not cleared.
- TDR write: the written word is updated lane-wise from wdata. The counter does not increment in that cycle, and the unwritten word keeps its value.
- Match: when {tdr_1, tdr_0} == {tcmp1, tcmp0} (current register values), tisr[0] is set on the next edge. This applies whether or not the timer is enabled, and regardless of tier.
- TISR[0] is write-1-to-clear and needs lane 0 strobed. If a set and a clear occur in the same cycle, the set wins and tisr[0] stays 1.

## Timing
- Every write takes effect on the pclk edge that samples wr_en = 1; the new value is visible on the outputs the following cycle.
- wr_err is valid in the same cycle as wr_en and carries no state.
- The counter advances one cycle after a tick condition.
- The match condition in cycle N sets tisr[0] at edge N+1; tim_int follows at edge N+2.
- presetn assertion at any point, including mid-count or mid-write, immediately forces all reset values. Release is synchronous to the next pclk edge.

## Test plan
- Reset, then write TCR = 0x0000_0001 with wstrb = 0xF → counter increments every cycle; after 10 cycles, tdr_0 = 10.
- Write TCR = 0x0000_0203 from the disabled state (div_en = 1, div_val = 2, timer_en = 1) → tdr_0 increments once every 4 cycles. Then, with the timer running, write TCR = 0x0000_0303 → wr_err = 1 and tcr stays 0x0000_0203. Write TCR = 0x0000_0903 → wr_err = 1.
- Write TDR0 = 0xFFFF_FFFE and TDR1 = 0xFFFF_FFFF, then enable with no division → after 2 ticks the counter wraps to tdr_0 = 0, tdr_1 = 0.
- Set TCMP0 = 5, TCMP1 = 0, TIER = 1, then enable → tisr = 1 one cycle after tdr_0 = 5, and tim_int = 1 one cycle later. Write TISR = 1 → tisr = 0 and tim_int drops.
- With tisr[0] = 1 and the counter held at the compare value, write TISR = 1 → tisr stays 1 because set beats clear.
- Write TCMP0 = 0xAABBCCDD with wstrb = 0x5 → tcmp0 = 0xFFBBFFDD. Assert presetn mid-count → all outputs immediately return to their reset values.

Source files
------------

// File: rtl/timer_reg_core_if.sv
// Write-transfer bundle between the APB slave front end and the timer register core.
// Latency: none, plain wires; wr_err is combinational in the core.
// Backpressure: none, every strobe is consumed in the cycle it is presented.
interface timer_reg_core_if;
   logic        wr_en;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [3:0]  wstrb;
   logic        wr_err;

   modport master (output wr_en, addr, wdata, wstrb, input wr_err);
   modport slave  (input wr_en, addr, wdata, wstrb, output wr_err);
endinterface

// File: rtl/timer_reg_core.sv
// Timer register file plus 64-bit counter, clock divider and compare-match interrupt.
// Latency: writes visible next cycle; match sets tisr next edge, tim_int one edge later.
// Backpressure: none; illegal TCR writes are dropped and flagged on wr_err in the same cycle.
module timer_reg_core #(
   parameter int unsigned DIV_MAX = 8
) (
   input  logic              pclk,
   input  logic              presetn,
   timer_reg_core_if.slave   bus,
   output logic [31:0]       tcr,
   output logic [31:0]       tdr_0,
   output logic [31:0]       tdr_1,
   output logic [31:0]       tcmp0,
   output logic [31:0]       tcmp1,
   output logic [31:0]       tier,
   output logic [31:0]       tisr,
   output logic              tim_int
);

   localparam logic [31:0] A_TCR   = 32'h00;
   localparam logic [31:0] A_TDR0  = 32'h04;
   localparam logic [31:0] A_TDR1  = 32'h08;
   localparam logic [31:0] A_TCMP0 = 32'h0C;
   localparam logic [31:0] A_TCMP1 = 32'h10;
   localparam logic [31:0] A_TIER  = 32'h14;
   localparam logic [31:0] A_TISR  = 32'h18;
   // timer_en, div_en and div_val are the only implemented TCR bits
   localparam logic [31:0] TCR_MASK = 32'h0000_0F03;

   logic [31:0] tcr_q, tcr_d, tdr0_q, tdr0_d, tdr1_q, tdr1_d;
   logic [31:0] tcmp0_q, tcmp0_d, tcmp1_q, tcmp1_d;
   logic        tier_q, tier_d, tisr_q, tisr_d, tim_int_q, tim_int_d;
   logic [15:0] div_cnt_q, div_cnt_d;

   logic        sel_tcr, sel_tdr0, sel_tdr1, sel_tcmp0, sel_tcmp1, sel_tier, sel_tisr;
   logic [31:0] tcr_mrg;
   logic        tcr_bad, tick, match;
   logic [15:0] div_term;
   logic [63:0] cnt_inc;

   // Byte-lane merge of a write into an existing register value
   function automatic logic [31:0] lane_merge(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
      logic [31:0] r;
      r = old_v;
      for (int i = 0; i < 4; i++) begin
         if (strb[i]) r[8*i +: 8] = new_v[8*i +: 8];
      end
      return r;
   endfunction

   // Address decode and TCR legality check on the lane-merged value
   always_comb begin
      sel_tcr   = bus.wr_en && (bus.addr == A_TCR);
      sel_tdr0  = bus.wr_en && (bus.addr == A_TDR0);
      sel_tdr1  = bus.wr_en && (bus.addr == A_TDR1);
      sel_tcmp0 = bus.wr_en && (bus.addr == A_TCMP0);
      sel_tcmp1 = bus.wr_en && (bus.addr == A_TCMP1);
      sel_tier  = bus.wr_en && (bus.addr == A_TIER);
      sel_tisr  = bus.wr_en && (bus.addr == A_TISR);
      tcr_mrg   = lane_merge(tcr_q, bus.wdata, bus.wstrb) & TCR_MASK;
      // Divider configuration is frozen while the timer runs
      tcr_bad   = (32'(tcr_mrg[11:8]) > DIV_MAX) ||
                  (tcr_q[0] && ((tcr_mrg[1] != tcr_q[1]) || (tcr_mrg[11:8] != tcr_q[11:8])));
   end

   assign bus.wr_err = sel_tcr && tcr_bad;

   // Divider tick generation, counter advance and register write-back
   always_comb begin
      div_term  = ~(16'hFFFF << tcr_q[11:8]);
      div_cnt_d = '0;
      tick      = tcr_q[0];
      if (tcr_q[0] && tcr_q[1]) begin
         tick      = (div_cnt_q == div_term);
         div_cnt_d = tick ? 16'd0 : div_cnt_q + 16'd1;
      end

      match   = ({tdr1_q, tdr0_q} == {tcmp1_q, tcmp0_q});
      cnt_inc = {tdr1_q, tdr0_q} + 64'd1;

      tdr0_d = tdr0_q;
      tdr1_d = tdr1_q;
      // A TDR write owns the cycle: the other word holds and no increment occurs
      if (sel_tdr0) begin
         tdr0_d = lane_merge(tdr0_q, bus.wdata, bus.wstrb);
      end else if (sel_tdr1) begin
         tdr1_d = lane_merge(tdr1_q, bus.wdata, bus.wstrb);
      end else if (tick) begin
         {tdr1_d, tdr0_d} = cnt_inc;
      end

      tcr_d   = (sel_tcr && !tcr_bad) ? tcr_mrg : tcr_q;
      tcmp0_d = sel_tcmp0 ? lane_merge(tcmp0_q, bus.wdata, bus.wstrb) : tcmp0_q;
      tcmp1_d = sel_tcmp1 ? lane_merge(tcmp1_q, bus.wdata, bus.wstrb) : tcmp1_q;
      tier_d  = (sel_tier && bus.wstrb[0]) ? bus.wdata[0] : tier_q;

      // Set from a match beats a simultaneous write-1-to-clear
      tisr_d = tisr_q;
      if (match) begin
         tisr_d = 1'b1;
      end else if (sel_tisr && bus.wstrb[0] && bus.wdata[0]) begin
         tisr_d = 1'b0;
      end

      tim_int_d = tisr_q & tier_q;
   end

   // State registers
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         tcr_q     <= 32'h0000_0100;
         tdr0_q    <= '0;
         tdr1_q    <= '0;
         tcmp0_q   <= 32'hFFFF_FFFF;
         tcmp1_q   <= 32'hFFFF_FFFF;
         tier_q    <= 1'b0;
         tisr_q    <= 1'b0;
         tim_int_q <= 1'b0;
         div_cnt_q <= '0;
      end else begin
         tcr_q     <= tcr_d;
         tdr0_q    <= tdr0_d;
         tdr1_q    <= tdr1_d;
         tcmp0_q   <= tcmp0_d;
         tcmp1_q   <= tcmp1_d;
         tier_q    <= tier_d;
         tisr_q    <= tisr_d;
         tim_int_q <= tim_int_d;
         div_cnt_q <= div_cnt_d;
      end
   end

   assign tcr     = tcr_q;
   assign tdr_0   = tdr0_q;
   assign tdr_1   = tdr1_q;
   assign tcmp0   = tcmp0_q;
   assign tcmp1   = tcmp1_q;
   assign tier    = {31'd0, tier_q};
   assign tisr    = {31'd0, tisr_q};
   assign tim_int = tim_int_q;

endmodule

// File: tb/tb_timer_reg_core.sv
// Self-checking bench for timer_reg_core: directed scenarios plus random writes.
// Latency: a reference model updated per edge is compared on every falling edge.
// Backpressure: not applicable; stimulus drives one write per cycle at most.
module tb_timer_reg_core;

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic [31:0] tcr, tdr_0, tdr_1, tcmp0, tcmp1, tier, tisr;
   logic        tim_int;

   timer_reg_core_if bus ();

   timer_reg_core #(.DIV_MAX(8)) dut (
      .pclk    (pclk),
      .presetn (presetn),
      .bus     (bus),
      .tcr     (tcr),
      .tdr_0   (tdr_0),
      .tdr_1   (tdr_1),
      .tcmp0   (tcmp0),
      .tcmp1   (tcmp1),
      .tier    (tier),
      .tisr    (tisr),
      .tim_int (tim_int)
   );

   always #5 pclk = ~pclk;

   int n_vec = 0;
   int n_bad = 0;
   bit chk_on = 1'b0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   logic [31:0] m_tcr = 32'h100, m_tdr0 = 0, m_tdr1 = 0;
   logic [31:0] m_cmp0 = 32'hFFFF_FFFF, m_cmp1 = 32'hFFFF_FFFF;
   logic        m_tier = 0, m_tisr = 0, m_int = 0;
   int          m_run = 0;

   function automatic logic [31:0] lanes(input logic [31:0] o, input logic [31:0] n,
                                         input logic [3:0] s);
      logic [31:0] r;
      for (int i = 0; i < 32; i++) r[i] = s[i/8] ? n[i] : o[i];
      return r;
   endfunction

   function automatic logic tcr_reject(input logic [31:0] cur, input logic [31:0] d,
                                       input logic [3:0] s);
      logic [31:0] nt;
      int          dv_new, dv_cur;
      nt     = lanes(cur, d, s);
      dv_new = int'(nt[11:8]);
      dv_cur = int'(cur[11:8]);
      if (dv_new > 8) return 1'b1;
      return cur[0] && ((nt[1] != cur[1]) || (dv_new != dv_cur));
   endfunction

   function automatic logic exp_err();
      return bus.wr_en && (bus.addr == 32'h0) && tcr_reject(m_tcr, bus.wdata, bus.wstrb);
   endfunction

   always @(posedge pclk or negedge presetn) begin
      longint unsigned cnt;
      int              period;
      bit              tick, hit, tdr_wr;
      logic [31:0]     a, d;
      logic [3:0]      s;
      logic [31:0]     n_tcr;
      logic            n_tisr;
      if (!presetn) begin
         m_tcr = 32'h100; m_tdr0 = 0; m_tdr1 = 0;
         m_cmp0 = 32'hFFFF_FFFF; m_cmp1 = 32'hFFFF_FFFF;
         m_tier = 0; m_tisr = 0; m_int = 0; m_run = 0;
      end else begin
         a = bus.addr; d = bus.wdata; s = bus.wstrb;
         cnt    = {m_tdr1, m_tdr0};
         hit    = (cnt == {m_cmp1, m_cmp0});
         period = m_tcr[1] ? (1 << m_tcr[11:8]) : 1;
         if (m_tcr[0] && m_tcr[1]) begin
            m_run++;
            tick = ((m_run % period) == 0);
         end else begin
            m_run = 0;
            tick  = m_tcr[0];
         end
         tdr_wr = bus.wr_en && (a == 32'h4 || a == 32'h8);
         n_tisr = m_tisr;
         if (hit) n_tisr = 1'b1;
         else if (bus.wr_en && a == 32'h18 && s[0] && d[0]) n_tisr = 1'b0;
         m_int = m_tisr & m_tier;
         m_tisr = n_tisr;
         if (!tdr_wr && tick) cnt = cnt + 64'd1;
         {m_tdr1, m_tdr0} = cnt;
         if (bus.wr_en) begin
            case (a)
               32'h00: if (!tcr_reject(m_tcr, d, s)) begin
                  n_tcr = lanes(m_tcr, d, s);
                  m_tcr = {20'd0, n_tcr[11:8], 6'd0, n_tcr[1:0]};
               end
               32'h04: m_tdr0 = lanes(m_tdr0, d, s);
               32'h08: m_tdr1 = lanes(m_tdr1, d, s);
               32'h0C: m_cmp0 = lanes(m_cmp0, d, s);
               32'h10: m_cmp1 = lanes(m_cmp1, d, s);
               32'h14: if (s[0]) m_tier = d[0];
               default: ;
            endcase
         end
      end
   end

   // Per-cycle comparison against the model, away from the active edge
   always @(negedge pclk) begin
      if (chk_on) begin
         chk("tcr", {32'd0, tcr}, {32'd0, m_tcr});
         chk("tdr", {tdr_1, tdr_0}, {m_tdr1, m_tdr0});
         chk("tcmp", {tcmp1, tcmp0}, {m_cmp1, m_cmp0});
         chk("tier", {32'd0, tier}, {63'd0, m_tier});
         chk("tisr", {32'd0, tisr}, {63'd0, m_tisr});
         chk("tim_int", {63'd0, tim_int}, {63'd0, m_int});
         chk("wr_err", {63'd0, bus.wr_err}, {63'd0, exp_err()});
      end
   end

   // ---------------- stimulus ----------------
   task automatic step(input int n);
      repeat (n) begin
         @(posedge pclk);
         #1;
      end
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                     output logic err);
      bus.wr_en = 1'b1; bus.addr = a; bus.wdata = d; bus.wstrb = s;
      @(negedge pclk);
      err = bus.wr_err;
      @(posedge pclk);
      #1;
      bus.wr_en = 1'b0;
   endtask

   logic e;

   initial begin
      bus.wr_en = 1'b0; bus.addr = '0; bus.wdata = '0; bus.wstrb = '0;
      #12;
      chk("rst_tcr", {32'd0, tcr}, 64'h100);
      chk("rst_tcmp0", {32'd0, tcmp0}, 64'hFFFF_FFFF);
      chk("rst_tim_int", {63'd0, tim_int}, 64'd0);
      @(negedge pclk);
      presetn = 1'b1;
      chk_on  = 1'b1;
      step(1);

      // lane-strobed compare write
      wr(32'h0C, 32'hAABB_CCDD, 4'h5, e);
      chk("tcmp0_strb", {32'd0, tcmp0}, 64'hFFBB_FFDD);
      wr(32'h0C, 32'hFFFF_FFFF, 4'hF, e);

      // undivided count
      wr(32'h00, 32'h1, 4'hF, e);
      step(10);
      chk("cnt10", {32'd0, tdr_0}, 64'd10);

      // stop, clear, divide by 4
      wr(32'h00, 32'h0, 4'h1, e);
      wr(32'h04, 32'h0, 4'hF, e);
      wr(32'h00, 32'h203, 4'hF, e);
      step(7);
      chk("div4_a", {32'd0, tdr_0}, 64'd1);
      step(1);
      chk("div4_b", {32'd0, tdr_0}, 64'd2);
      wr(32'h00, 32'h303, 4'hF, e);
      chk("err_divchg", {63'd0, e}, 64'd1);
      chk("tcr_kept", {32'd0, tcr}, 64'h203);
      wr(32'h00, 32'h903, 4'hF, e);
      chk("err_divmax", {63'd0, e}, 64'd1);

      // 64-bit wrap; the all-ones value also matches the reset compare value
      wr(32'h00, 32'h2, 4'h1, e);
      chk("err_stop", {63'd0, e}, 64'd0);
      wr(32'h00, 32'h0, 4'hF, e);
      wr(32'h04, 32'hFFFF_FFFE, 4'hF, e);
      wr(32'h08, 32'hFFFF_FFFF, 4'hF, e);
      wr(32'h00, 32'h1, 4'hF, e);
      step(2);
      chk("wrap", {tdr_1, tdr_0}, 64'd0);
      chk("wrap_hit", {32'd0, tisr}, 64'd1);
      wr(32'h18, 32'h1, 4'h1, e);
      chk("w1c", {32'd0, tisr}, 64'd0);

      // compare match and interrupt
      wr(32'h00, 32'h0, 4'h1, e);
      wr(32'h04, 32'h0, 4'hF, e);
      wr(32'h08, 32'h0, 4'hF, e);
      wr(32'h0C, 32'h5, 4'hF, e);
      wr(32'h10, 32'h0, 4'hF, e);
      wr(32'h14, 32'h1, 4'hF, e);
      wr(32'h00, 32'h1, 4'hF, e);
      step(5);
      chk("at5", {32'd0, tdr_0}, 64'd5);
      chk("at5_tisr", {32'd0, tisr}, 64'd0);
      step(1);
      chk("tisr_set", {32'd0, tisr}, 64'd1);
      chk("int_lag", {63'd0, tim_int}, 64'd0);
      step(1);
      chk("int_set", {63'd0, tim_int}, 64'd1);
      wr(32'h18, 32'h1, 4'h1, e);
      chk("tisr_clr", {32'd0, tisr}, 64'd0);
      step(1);
      chk("int_drop", {63'd0, tim_int}, 64'd0);

      // set beats clear
      wr(32'h00, 32'h0, 4'h1, e);
      wr(32'h04, 32'h5, 4'hF, e);
      step(1);
      chk("hold_set", {32'd0, tisr}, 64'd1);
      wr(32'h18, 32'h1, 4'h1, e);
      chk("set_wins", {32'd0, tisr}, 64'd1);

      // asynchronous reset mid-count
      wr(32'h00, 32'h1, 4'h1, e);
      step(3);
      @(negedge pclk);
      #2;
      presetn = 1'b0;
      #1;
      chk("arst_tcr", {32'd0, tcr}, 64'h100);
      chk("arst_tdr", {tdr_1, tdr_0}, 64'd0);
      chk("arst_tcmp", {tcmp1, tcmp0}, 64'hFFFF_FFFF_FFFF_FFFF);
      chk("arst_tisr", {tisr, tier}, 64'd0);
      chk("arst_int", {63'd0, tim_int}, 64'd0);
      @(posedge pclk);
      #3;
      presetn = 1'b1;
      step(1);

      // random writes against the model
      for (int i = 0; i < 1500; i++) begin
         int          k;
         logic [31:0] a, d;
         logic [3:0]  s;
         k = int'($urandom_range(0, 9));
         s = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
         case (k)
            0: a = 32'h00;
            1: a = 32'h04;
            2: a = 32'h08;
            3: a = 32'h0C;
            4: a = 32'h10;
            5: a = 32'h14;
            6: a = 32'h18;
            7: a = 32'h1C;
            8: a = 32'h02;
            default: a = $urandom;
         endcase
         case (k)
            0: d = {20'd0, 4'($urandom_range(0, 10)), 6'd0, 2'($urandom)} |
                   (($urandom_range(0, 3) == 0) ? ($urandom & 32'hFFFF_F0FC) : 32'd0);
            1, 3: d = $urandom_range(0, 60);
            2, 4: d = ($urandom_range(0, 3) == 0) ? $urandom : 32'd0;
            default: d = $urandom;
         endcase
         if ($urandom_range(0, 2) == 0) begin
            step(int'($urandom_range(1, 6)));
         end else begin
            wr(a, d, s, e);
         end
      end
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
